// File: rtl/cmd_resp.sv
// Device-side command responder: buffers RX bytes up to TERM, then sends a 5-byte AOK/ERR reply on TX.
// Optional CMD_TIMEOUT_EN adds an inter-byte timeout that abandons a stalled command.
module UART #(
  parameter logic [15:0] BAUD_DIV = 16'd2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy,
  output logic [7:0] rx_data,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);
  logic        rx_s1, rx_s, rx_busy;
  logic [15:0] rx_cnt;
  logic [3:0]  rx_bits;
  logic [7:0]  rx_shift;
  logic        tx_busy;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bits;
  logic [8:0]  tx_shift;

  assign rx_data = rx_shift;
  assign TX      = tx_busy ? tx_shift[0] : 1'b1;

  // Receiver: first sample lands mid start bit, later samples one bit apart.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1; rx_s <= 1'b1; rx_busy <= 1'b0;
      rx_cnt <= '0; rx_bits <= '0; rx_shift <= '0; rx_rdy <= 1'b0;
    end else begin
      rx_s1 <= RX;
      rx_s  <= rx_s1;
      if (clr_rx_rdy) rx_rdy <= 1'b0;
      if (!rx_busy) begin
        if (!rx_s) begin
          rx_busy <= 1'b1;
          rx_cnt  <= BAUD_DIV >> 1;
          rx_bits <= '0;
        end
      end else if (rx_cnt == '0) begin
        rx_cnt  <= BAUD_DIV - 16'd1;
        rx_bits <= rx_bits + 4'd1;
        if (rx_bits == 4'd0) begin
          if (rx_s) rx_busy <= 1'b0;
        end else if (rx_bits == 4'd9) begin
          rx_busy <= 1'b0;
          rx_rdy  <= 1'b1;
        end else begin
          rx_shift <= {rx_s, rx_shift[7:1]};
        end
      end else begin
        rx_cnt <= rx_cnt - 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_busy <= 1'b0; tx_cnt <= '0; tx_bits <= '0; tx_shift <= '1; tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy) begin
        if (trmt) begin
          tx_busy  <= 1'b1;
          tx_shift <= {tx_data, 1'b0};
          tx_cnt   <= BAUD_DIV - 16'd1;
          tx_bits  <= '0;
        end
      end else if (tx_cnt == '0) begin
        if (tx_bits == 4'd9) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          tx_shift <= {1'b1, tx_shift[8:1]};
          tx_bits  <= tx_bits + 4'd1;
          tx_cnt   <= BAUD_DIV - 16'd1;
        end
      end else begin
        tx_cnt <= tx_cnt - 16'd1;
      end
    end
  end
endmodule

module cmd_resp #(
  parameter int          MAX_CMD_LEN = 16,
  parameter logic [7:0]  TERM        = 8'h0D,
  parameter logic [15:0] BAUD_DIV    = 16'd2604
`ifdef CMD_TIMEOUT_EN
  , parameter logic [19:0] TIMEOUT_CYC = 20'd1_000_000
`endif
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           RX,
  output logic                           TX,
  output logic                           cmd_rdy,
  output logic [$clog2(MAX_CMD_LEN):0]   cmd_len,
  input  logic [$clog2(MAX_CMD_LEN)-1:0] rd_idx,
  output logic [7:0]                     rd_byte,
  output logic                           busy
);
  localparam int IW = $clog2(MAX_CMD_LEN);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] MAX_PTR = PW'(MAX_CMD_LEN);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] COLLECT   = 2'd1;
  localparam logic [1:0] RESP      = 2'd2;
  localparam logic [1:0] RESP_WAIT = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] wr_ptr;
  logic          ovf;
  logic [2:0]    resp_idx;
  logic [7:0]    buf_mem [MAX_CMD_LEN];
  logic          rx_rdy, trmt, tx_done, to_hit, buf_we;
  logic [7:0]    rx_data, tx_data;
  logic [IW-1:0] wr_addr;

  UART #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX),
    .rx_rdy(rx_rdy), .clr_rx_rdy(rx_rdy), .rx_data(rx_data),
    .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done)
  );

  assign busy    = (state != IDLE);
  assign trmt    = (state == RESP);
  assign rd_byte = buf_mem[rd_idx];

`ifdef CMD_TIMEOUT_EN
  logic [19:0] to_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n || state == IDLE || rx_rdy) to_cnt <= '0;
    else if (state == COLLECT)             to_cnt <= to_cnt + 20'd1;
  end
  assign to_hit = (state == COLLECT) && (to_cnt == TIMEOUT_CYC - 20'd1);
`else
  assign to_hit = 1'b0;
`endif

  // ovf stays put from terminator until the reply finishes, so it selects the table.
  always_comb begin
    tx_data = 8'h0A;
    case (resp_idx)
      3'd0:    tx_data = ovf ? 8'h45 : 8'h41;
      3'd1:    tx_data = ovf ? 8'h52 : 8'h4F;
      3'd2:    tx_data = ovf ? 8'h52 : 8'h4B;
      3'd3:    tx_data = 8'h0D;
      default: tx_data = 8'h0A;
    endcase
  end

  always_comb begin
    wr_addr = (state == IDLE) ? '0 : wr_ptr[IW-1:0];
    buf_we  = rx_rdy && (rx_data != TERM) &&
              ((state == IDLE) || (state == COLLECT && wr_ptr < MAX_PTR));
  end

  always_ff @(posedge clk) begin
    if (rst_n && buf_we) buf_mem[wr_addr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE; wr_ptr <= '0; ovf <= 1'b0; resp_idx <= '0;
      cmd_rdy <= 1'b0; cmd_len <= '0;
    end else begin
      cmd_rdy <= 1'b0;
      case (state)
        IDLE: if (rx_rdy) begin
          if (rx_data == TERM) begin
            cmd_len <= '0;
            cmd_rdy <= 1'b1;
            state   <= RESP;
          end else begin
            wr_ptr <= PW'(1);
            state  <= COLLECT;
          end
        end
        COLLECT: if (rx_rdy) begin
          if (rx_data == TERM) begin
            cmd_len <= wr_ptr;
            cmd_rdy <= ~ovf;
            state   <= RESP;
          end else if (wr_ptr < MAX_PTR) begin
            wr_ptr <= wr_ptr + PW'(1);
          end else begin
            ovf <= 1'b1;
          end
        end else if (to_hit) begin
          state <= IDLE; wr_ptr <= '0; ovf <= 1'b0;
        end
        RESP: state <= RESP_WAIT;
        RESP_WAIT: if (tx_done) begin
          if (resp_idx == 3'd4) begin
            state <= IDLE; wr_ptr <= '0; ovf <= 1'b0; resp_idx <= '0;
          end else begin
            resp_idx <= resp_idx + 3'd1;
            state    <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmd_resp.sv
// Scoreboard bench for cmd_resp: a bit-level serial driver on RX and decoder on TX.
module tb_cmd_resp;
  localparam int BAUD = 16;

  logic       clk = 1'b0, rst_n = 1'b0, RX = 1'b1;
  logic       TX, cmd_rdy, busy;
  logic [4:0] cmd_len;
  logic [3:0] rd_idx = '0;
  logic [7:0] rd_byte;

  int n_checks = 0, n_errors = 0;
  int rdy_cnt = 0, n_rx = 0;
  logic [4:0] last_len = '0;
  logic rst_seen = 1'b0;
  logic [7:0] exp_q [$];

  cmd_resp #(.MAX_CMD_LEN(16), .TERM(8'h0D), .BAUD_DIV(16'(BAUD))
`ifdef CMD_TIMEOUT_EN
    , .TIMEOUT_CYC(20'd1000)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd_rdy(cmd_rdy),
    .cmd_len(cmd_len), .rd_idx(rd_idx), .rd_byte(rd_byte), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BAUD) @(negedge clk);
    end
    RX = 1'b1;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic push_reply(input logic err);
    if (err) begin
      exp_q.push_back(8'h45); exp_q.push_back(8'h52); exp_q.push_back(8'h52);
    end else begin
      exp_q.push_back(8'h41); exp_q.push_back(8'h4F); exp_q.push_back(8'h4B);
    end
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
  endtask

  task automatic wait_done(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200 * BAUD; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic check_rd(input string tag, input logic [3:0] idx, input logic [7:0] exp);
    rd_idx = idx;
    #1;
    check(tag, {24'd0, rd_byte}, {24'd0, exp});
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b0) rst_seen = 1'b1;
    if (rst_n === 1'b1 && cmd_rdy === 1'b1) begin
      rdy_cnt++;
      last_len = cmd_len;
    end
  end

  // TX decoder: frames overlapping a reset are discarded as aborted.
  initial begin
    logic [7:0] b;
    logic       stop;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (TX === 1'b0) begin
        rst_seen = 1'b0;
        repeat (BAUD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = TX;
        end
        repeat (BAUD) @(negedge clk);
        stop = TX;
        if (!rst_seen) begin
          n_rx++;
          e = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
          check("tx_byte", {23'd0, 1'b0, b}, {23'd0, e});
          check("tx_stop", {31'd0, stop}, 32'd1);
        end
      end
    end
  end

  initial begin
    int r0, x0;
    logic [7:0] c1 [4];
    logic ok;
    c1[0] = 8'h53; c1[1] = 8'h3D; c1[2] = 8'h30; c1[3] = 8'h0D;

    repeat (5) @(negedge clk);
    check("rst_tx", {31'd0, TX}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("rst_cmd_len", {27'd0, cmd_len}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic three-byte command
    r0 = rdy_cnt; x0 = n_rx;
    push_reply(1'b0);
    for (int i = 0; i < 4; i++) send_byte(c1[i]);
    wait_done("c1_done");
    check("c1_rdy_pulses", rdy_cnt - r0, 1);
    check("c1_len_at_rdy", {27'd0, last_len}, 32'd3);
    check("c1_cmd_len", {27'd0, cmd_len}, 32'd3);
    check_rd("c1_rd0", 4'd0, 8'h53);
    check_rd("c1_rd1", 4'd1, 8'h3D);
    check_rd("c1_rd2", 4'd2, 8'h30);
    check("c1_busy", {31'd0, busy}, 32'd0);
    check("c1_nrx", n_rx - x0, 5);

    // Empty command
    r0 = rdy_cnt;
    push_reply(1'b0);
    send_byte(8'h0D);
    wait_done("empty_done");
    check("empty_rdy_pulses", rdy_cnt - r0, 1);
    check("empty_cmd_len", {27'd0, cmd_len}, 32'd0);

    // Overflow: 20 bytes into a 16-deep buffer
    r0 = rdy_cnt;
    push_reply(1'b1);
    for (int i = 0; i < 20; i++) send_byte(8'h41);
    send_byte(8'h0D);
    wait_done("ovf_done");
    check("ovf_no_rdy", rdy_cnt - r0, 0);
    check("ovf_cmd_len", {27'd0, cmd_len}, 32'd16);
    r0 = rdy_cnt;
    push_reply(1'b0);
    send_byte(8'h42); send_byte(8'h0D);
    wait_done("post_ovf_done");
    check("post_ovf_rdy", rdy_cnt - r0, 1);
    check("post_ovf_len", {27'd0, cmd_len}, 32'd1);
    check_rd("post_ovf_rd0", 4'd0, 8'h42);

    // Bytes arriving mid-reply are ignored
    r0 = rdy_cnt; x0 = n_rx;
    push_reply(1'b0);
    send_byte(8'h55); send_byte(8'h0D);
    send_byte(8'h77); send_byte(8'h0D);
    wait_done("inject_done");
    repeat (15 * BAUD) @(negedge clk);
    check("inject_nrx", n_rx - x0, 5);
    check("inject_rdy", rdy_cnt - r0, 1);
    check("inject_len", {27'd0, cmd_len}, 32'd1);
    check_rd("inject_rd0", 4'd0, 8'h55);

    // Reset during the third reply byte
    x0 = n_rx;
    push_reply(1'b0);
    send_byte(8'h56); send_byte(8'h0D);
    ok = 1'b0;
    for (int i = 0; i < 40 * BAUD; i++) begin
      @(negedge clk);
      if (n_rx - x0 == 2) begin ok = 1'b1; break; end
    end
    check("rst3_two_bytes", {31'd0, ok}, 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 4 * BAUD; i++) begin
      @(negedge clk);
      if (TX === 1'b0) begin ok = 1'b1; break; end
    end
    check("rst3_third_start", {31'd0, ok}, 32'd1);
    repeat (3 * BAUD) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst3_busy", {31'd0, busy}, 32'd0);
    check("rst3_cmd_len", {27'd0, cmd_len}, 32'd0);
    check("rst3_tx_idle", {31'd0, TX}, 32'd1);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    r0 = rdy_cnt; x0 = n_rx;
    push_reply(1'b0);
    send_byte(8'h56); send_byte(8'h0D);
    wait_done("rst3_fresh_done");
    check("rst3_fresh_rdy", rdy_cnt - r0, 1);
    check("rst3_fresh_len", {27'd0, cmd_len}, 32'd1);
    check("rst3_fresh_nrx", n_rx - x0, 5);

`ifdef CMD_TIMEOUT_EN
    // Stalled command is abandoned; the late terminator is an empty command
    r0 = rdy_cnt;
    send_byte(8'h41);
    repeat (1200) @(negedge clk);
    check("to_idle", {31'd0, busy}, 32'd0);
    push_reply(1'b0);
    send_byte(8'h0D);
    wait_done("to_done");
    check("to_rdy", rdy_cnt - r0, 1);
    check("to_cmd_len", {27'd0, cmd_len}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cmd_resp.md
Name: cmd_resp

Overview:
- UART-side responder that sits at the far end of the command link: it is the device-side counterpart of the command sender.
- Receives command bytes on RX and buffers them until the CR terminator (8'h0D) arrives.
- After the terminator, transmits a fixed 5-byte reply on TX that ends in 8'h0A. The sender uses that final byte as its "response received" marker.
- Used as the synthesizable BT-module stand-in for system benches and FPGA loopback; it also exposes the captured command for checking.

Parameters:
- MAX_CMD_LEN, 16, depth of the command byte buffer in bytes (power of 2, 4..32).
- TERM, 8'h0D, command terminator byte.
- TIMEOUT_CYC, 20'd1_000_000, inter-byte timeout in clk cycles. Used only when CMD_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- RX  input  1  serial in from the command sender
- TX  output  1  serial out to the command sender
- cmd_rdy  output  1  one-cycle pulse: a complete, non-overflowed command has been captured
- cmd_len  output  $clog2(MAX_CMD_LEN)+1  byte count of the last captured command, terminator excluded
- rd_idx  input  $clog2(MAX_CMD_LEN)  buffer read index
- rd_byte  output  8  buffer[rd_idx], combinational read
- busy  output  1  high while in COLLECT, RESP or RESP_WAIT

Behaviour:
- Instantiates the codebase UART (clk, rst_n, RX, TX, rx_rdy, clr_rx_rdy, rx_data, trmt, tx_data, tx_done) with clr_rx_rdy tied to rx_rdy, so each received byte is consumed the cycle it appears.
- Reset (rst_n low at posedge clk):
  - state=IDLE, wr_ptr=0, ovf=0, resp_idx=0.
  - cmd_rdy=0, cmd_len=0, busy=0.
  - TX is held idle high by the UART.
  - Buffer contents are don't-care.
  - Reset mid-reply aborts the reply; the partial byte on the wire is not completed.
- State machine (IDLE, COLLECT, RESP, RESP_WAIT):
  - IDLE, rx_rdy with byte != TERM: store it at buffer[0], wr_ptr=1, go to COLLECT.
  - IDLE, rx_rdy with byte == TERM: empty command. cmd_len=0, pulse cmd_rdy, go to RESP with the AOK reply.
  - COLLECT, rx_rdy with byte != TERM:
    - if wr_ptr < MAX_CMD_LEN: buffer[wr_ptr]=byte, wr_ptr+1;
    - else set ovf and drop the byte; wr_ptr saturates at MAX_CMD_LEN.
  - COLLECT, rx_rdy with byte == TERM:
    - cmd_len <= wr_ptr next cycle.
    - cmd_rdy pulses in the same cycle cmd_len updates, only if ovf==0.
    - Go to RESP.
  - RESP: assert trmt for exactly one cycle with tx_data = reply[resp_idx], then go to RESP_WAIT.
  - RESP_WAIT: wait for tx_done.
    - If resp_idx==4: go to IDLE and clear wr_ptr, ovf and resp_idx.
    - Else resp_idx+1, go to RESP.
- Reply tables:
  - ovf==0: "AOK\r\n" = 41 4F 4B 0D 0A.
  - ovf==1: "ERR\r\n" = 45 52 52 0D 0A.
  - The table is selected when the terminator is seen and held for the whole reply.
- Bytes received during RESP or RESP_WAIT are discarded. They are not buffered and do not change cmd_len.
- trmt is never asserted again until tx_done for the previous byte. Exactly 5 trmt pulses per command.
- cmd_len and the buffer hold their values until the next command's first byte is written.
- A single RX byte changes at most one pointer per cycle.

Optional Feature:
- CMD_TIMEOUT_EN defined:
  - A 20-bit counter clears on every rx_rdy and counts while in COLLECT.
  - When it reaches TIMEOUT_CYC-1: go to IDLE, clear wr_ptr and ovf. No reply, no cmd_rdy.
  - The counter is cleared by reset and on entry to IDLE.
- Not defined: no counter is generated, and COLLECT waits for TERM indefinitely.

Test Plan:
- Send 53 3D 30 0D -> cmd_rdy one pulse, cmd_len=3, rd_byte at idx 0..2 = 53,3D,30; TX carries 41 4F 4B 0D 0A; busy low after the final tx_done.
- Send 0D alone -> cmd_rdy pulse, cmd_len=0, AOK reply.
- Send 20 bytes of 41 then 0D with MAX_CMD_LEN=16 -> no cmd_rdy, TX carries 45 52 52 0D 0A; a next command 42 0D gives cmd_len=1, AOK.
- Send 55 0D, then inject 77 0D during the reply -> exactly 5 reply bytes, cmd_len stays 1, no second cmd_rdy.
- Assert rst_n low during the 3rd reply byte -> next cycle busy=0, cmd_len=0; a fresh 56 0D gets a full AOK.
- With CMD_TIMEOUT_EN and TIMEOUT_CYC=1000: send 41, idle 1200 cycles, send 0D -> the 0D is treated as an empty command: cmd_len=0, AOK.
